// File: rtl/pc_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_responder
// Description : Consumer end of the PC fetch interface. Captures a fetch
//               address on the GetInstruction strobe, reads the instruction
//               word over a valid/ready memory port, and queues
//               {address, word} pairs in a small in-order FIFO for decode.
//
//               Ports:
//                 clk, rst          clock, synchronous active-low reset
//                 PCAddr            fetch address from the PC
//                 GetInstruction    one-cycle fetch strobe
//                 Flush             drop queued and in-flight fetches
//                 FetchBusy         pending slot full; a strobe now is dropped
//                 FetchOverrun      sticky: a strobe has been dropped
//                 MemAddr/MemRead   memory read request (held until MemReady)
//                 MemReady/MemData  memory read response
//                 Instr/InstrAddr   FIFO head word and its address
//                 InstrValid        FIFO non-empty
//                 InstrReady        decoder pops the head
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCAddr,
    input  logic              GetInstruction,
    input  logic              Flush,
    output logic              FetchBusy,
    output logic              FetchOverrun,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic              MemReady,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic              InstrValid,
    input  logic              InstrReady
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_slot_valid;
    logic [ADDR_W-1:0] r_slot_addr;
    logic              r_overrun;
    logic [ADDR_W-1:0] r_addr_q;

    logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_mem_done;
    logic               w_free;
    logic               w_slot_live;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_launch;
    logic [ADDR_W-1:0]  w_launch_addr;

    // The outstanding read (REQ or DRAIN) completes on MemReady; the request
    // port is then free to start another read in the same cycle.
    assign w_mem_done  = (r_state != ST_IDLE) && MemReady;
    assign w_free      = (r_state == ST_IDLE) || w_mem_done;

    // Flush empties the slot at this edge, so a same-cycle strobe lands in
    // an empty slot and is always accepted as the new PC target.
    assign w_slot_live = r_slot_valid && !Flush;
    assign w_accept    = GetInstruction && (Flush || !r_slot_valid);

    // Only REQ data is kept; DRAIN data and data racing a Flush are dropped.
    assign w_push = (r_state == ST_REQ) && MemReady && !Flush;
    assign w_pop  = (r_count != '0) && InstrReady;

    assign w_count_next = Flush ? '0
                        : r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    // A new read is started only if its word will fit once it returns: the
    // post-edge occupancy plus the word in flight must not exceed the depth.
    // A strobe with an empty slot bypasses the slot so MemRead rises on the
    // very next cycle.
    assign w_launch      = w_free && (w_slot_live || w_accept)
                        && (w_count_next < c_DEPTH_CNT);
    assign w_launch_addr = w_slot_live ? r_slot_addr : PCAddr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        MemRead      = 1'b0;
        if (r_state != ST_IDLE) begin
            MemRead = 1'b1;
        end
        if (w_launch) begin
            w_state_next = ST_REQ;
        end else if (w_free) begin
            w_state_next = ST_IDLE;
        end else if ((r_state == ST_REQ) && Flush) begin
            w_state_next = ST_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_slot_valid <= 1'b0;
            r_slot_addr  <= '0;
            r_overrun    <= 1'b0;
            r_addr_q     <= '0;
        end else begin
            if (w_launch) begin
                r_addr_q <= w_launch_addr;
            end
            if (w_slot_live) begin
                r_slot_valid <= !w_launch;
            end else begin
                r_slot_valid <= w_accept && !w_launch;
                if (w_accept && !w_launch) begin
                    r_slot_addr <= PCAddr;
                end
            end
            r_overrun <= Flush ? 1'b0
                       : (r_overrun || (GetInstruction && r_slot_valid));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (Flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= MemData;
            r_fifo_addr[r_wr_ptr] <= r_addr_q;
        end
    end

    assign FetchBusy    = r_slot_valid;
    assign FetchOverrun = r_overrun;
    assign MemAddr      = r_addr_q;
    assign InstrValid   = (r_count != '0);
    assign Instr        = InstrValid ? r_fifo_data[r_rd_ptr] : '0;
    assign InstrAddr    = InstrValid ? r_fifo_addr[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: doc/pc_fetch_responder.md
Name: pc_fetch_responder

Overview:
- Consumer end of the PC interface: takes the PC's PCAddr plus GetInstruction strobe, fetches the 32-bit word from instruction memory and returns it to the decoder.
- Memory side is a valid/ready read port; decoder side is a small in-order instruction FIFO that also carries each word's address.
- Sits between the PC and the decode stage of the CPU; a FetchBusy back-pressure line tells the PC controller to hold its next strobe.

Parameters:
- ADDR_W, 32, address width; must equal the PC width.
- DATA_W, 32, instruction word width.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset.
- PCAddr  in  ADDR_W  fetch address from the PC.
- GetInstruction  in  1  one-cycle fetch strobe from the PC.
- Flush  in  1  discard all queued and in-flight fetches (branch/jump).
- FetchBusy  out  1  pending slot occupied; a strobe arriving now is dropped.
- FetchOverrun  out  1  sticky: a strobe was dropped.
- MemAddr  out  ADDR_W  memory read address.
- MemRead  out  1  read request, held until accepted.
- MemReady  in  1  memory returns MemData this cycle.
- MemData  in  DATA_W  read data.
- Instr  out  DATA_W  FIFO head word.
- InstrAddr  out  ADDR_W  address of the FIFO head word.
- InstrValid  out  1  FIFO non-empty.
- InstrReady  in  1  decoder pops the head when InstrValid is high.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE; FIFO, pending slot and FetchOverrun cleared.
  - All outputs read 0, including MemRead, MemAddr, Instr and InstrAddr.
  - Reset during an outstanding read drops MemRead next cycle; memory must tolerate an abandoned request.
- Pending slot (1 entry):
  - GetInstruction with FetchBusy=0 latches PCAddr into the slot.
  - GetInstruction with FetchBusy=1 is ignored and sets FetchOverrun. FetchOverrun clears only on reset or Flush.
- FSM states:
  - IDLE: if the slot is full and (FIFO count + 0 outstanding) < FIFO_DEPTH, move the slot to addr_q, free the slot, go to REQ.
  - REQ: MemRead=1, MemAddr=addr_q. On MemReady=1, write {addr_q, MemData} into the FIFO. Then go to REQ again if the slot is full and space allows; otherwise go to IDLE.
  - DRAIN: entered on Flush while in REQ. MemRead stays 1 with the old address until MemReady. Returned data is discarded, then go to IDLE (or REQ if a post-flush request is pending).
- Space rule: a request is issued only when count < FIFO_DEPTH, counting the word in flight, so the FIFO can never overflow.
- Latency:
  - GetInstruction at cycle N with the block idle gives MemRead=1 at N+1.
  - MemReady at cycle M gives InstrValid=1 at M+1.
  - Minimum strobe-to-valid latency is 2 cycles.
  - Back-to-back fetches reach one word per cycle while MemReady stays high and the decoder pops.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - A pop while empty is ignored.
  - Instr and InstrAddr are stable while InstrValid=1 and InstrReady=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Flush:
  - Same-edge effect: clears the FIFO and slot, and any MemData arriving that cycle is discarded.
  - GetInstruction in the same cycle as Flush is accepted into the now-empty slot (new PC target).
- FetchBusy = slot full.
- No alignment check; PCAddr passes through unmodified.

Test Plan:
- Reset then single fetch: rst low 2 cycles, PCAddr=5791 strobe, MemReady=1 on the first MemRead cycle, MemData=0xDEADBEEF → MemAddr=5791 at N+1; Instr=0xDEADBEEF, InstrAddr=5791, InstrValid=1 at N+2.
- Back-pressure: decoder InstrReady=0, strobes 7894, 7898, 7902, MemReady=1 → FIFO holds 7894 and 7898; 7902 sits in the slot with MemRead=0 and FetchBusy=1. A fourth strobe sets FetchOverrun. After one pop, 7902 is fetched.
- Slow memory: strobe 33, MemReady low for 5 cycles → MemRead/MemAddr=33 held for 6 cycles; InstrValid rises the cycle after MemReady.
- Flush mid-read: strobe 7894, Flush plus strobe 33 while MemRead is high and MemReady is low → DRAIN. The 7894 data is dropped when it returns, then the fetch of 33 is issued; only InstrAddr=33 ever appears.
- Simultaneous push and pop: FIFO count 1, decoder popping while MemReady returns → count stays 1, order preserved.
- Reset mid-operation: rst low during REQ with 2 words queued → next cycle MemRead=0, InstrValid=0, FetchBusy=0, FetchOverrun=0.
